read_mem: RTL and testbench
===========================

# read_mem

Read-out engine for the logic analyzer's circular capture buffer; it is the reader-side counterpart of `write_mem`. On a `start` pulse it snapshots the write pointer and the `primed` flag, then walks the buffer in chronological order, oldest sample first. Each sample is presented on a valid/ready stream toward the host/UART side. It drives the buffer's synchronous read port and sits between capture memory and the transmit path.

## Interface
- `DATA_WIDTH`, 8: sample width; must match the capture buffer.
- `ADDR_WIDTH`, 4: buffer address width; buffer depth is `MEMORY_SIZE = 2**ADDR_WIDTH`.

Ports, with clock and reset first:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `start`, input, 1: single-cycle request to dump the buffer; sampled only in IDLE.
- `waddr`, input, `ADDR_WIDTH`: write pointer from the writer, i.e. the next location to be written.
- `primed`, input, 1: high when every buffer location has been written at least once.
- `raddr`, output, `ADDR_WIDTH`: read address to the buffer.
- `rdata`, input, `DATA_WIDTH`: buffer read data, valid one cycle after `raddr` is sampled.
- `o_data`, output, `DATA_WIDTH`: current sample.
- `o_valid`, output, 1: `o_data` is valid.
- `o_ready`, input, 1: downstream accepts the sample.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the last sample transfers, or after an empty dump.

## Operation
- States: IDLE, FETCH, WAIT, PRESENT, DONE.
- **IDLE**
  - On `start`: latch `base` and `count`.
  - If `primed`: `base = waddr`, `count = MEMORY_SIZE`.
  - Else: `base = 0`, `count = waddr`.
  - Next state is FETCH if `count != 0`, otherwise DONE.
- **FETCH**: `raddr = base + idx`, computed modulo `MEMORY_SIZE` (natural `ADDR_WIDTH` wrap); go to WAIT.
- **WAIT**: the memory registers the address; at the clock edge `o_data <= rdata`; go to PRESENT.
- **PRESENT**
  - `o_valid = 1`; `o_data` and `raddr` hold stable.
  - On `o_valid && o_ready`, increment `idx`.
  - If this was the last sample (`idx == count-1`), go to DONE; otherwise go to FETCH.
- **DONE**: `done = 1` for exactly one cycle, then IDLE.
- Width rules:
  - `count` and `idx` are `ADDR_WIDTH+1` bits, so the full depth `MEMORY_SIZE` is representable.
  - `raddr` uses only the low `ADDR_WIDTH` bits of `base + idx`.
- `start` is ignored in every state except IDLE, with no queuing.
- `waddr` and `primed` are sampled only on the accepted `start`. Later changes do not affect an ongoing dump.
- `o_valid`, once asserted, stays high until the handshake completes (no retraction).

## Timing
- Reset values:
  - State is IDLE.
  - `raddr = 0`, `o_data = 0`, `o_valid = 0`, `busy = 0`, `done = 0`.
  - Internal `base`, `count` and `idx` are 0.
- `start` is sampled at edge E0, and `busy` rises after E0.
- First sample:
  - `raddr` holds the first address during the cycle after E0 (FETCH).
  - `rdata` is valid after E1 (WAIT).
  - `o_valid` rises after E2.
- Per sample: `o_valid` rises 2 cycles after entering FETCH. Minimum spacing between accepted samples is 3 cycles (FETCH, WAIT, PRESENT).
- Transfer occurs at the edge where `o_valid && o_ready`; `o_valid` drops in the following cycle.
- `done` is high for one cycle immediately after the last transfer edge. `busy` falls one cycle after that.
- Empty dump (unprimed, `waddr = 0`): `done` is high in the cycle after E0, with no `o_valid`.
- Asynchronous `reset` mid-dump forces all outputs to their reset values immediately, with no `done` pulse. The next `start` begins a fresh dump.

## Test plan
- **Unprimed partial buffer:** `primed = 0`, `waddr = 5`, pulse `start`, `o_ready = 1`.
  - Expect `raddr` sequence 0,1,2,3,4 and `o_data` equal to `mem[0..4]` in order.
  - Expect `done` one cycle after the 5th transfer.
- **Primed wrap:** `ADDR_WIDTH = 4`, `primed = 1`, `waddr = 3`, `o_ready = 1`.
  - Expect 16 samples from addresses 3..15 then 0..2.
  - Expect no duplicates or skips, and `done` after the 16th transfer.
- **Empty dump:** `primed = 0`, `waddr = 0`, pulse `start`.
  - Expect `o_valid` to stay low.
  - Expect `done` high for one cycle, the cycle after `start`, and `busy` to return low.
- **Backpressure:** hold `o_ready = 0` for 5 cycles during the first PRESENT.
  - Expect `o_valid` high and `o_data`/`raddr` stable throughout.
  - On release, the sample transfers once and the sequence continues unchanged.
- **Start while busy:** pulse `start` again mid-dump and change `waddr` and `primed`.
  - Expect the dump to complete with the originally latched base and count.
  - Expect exactly one `done`.
- **Reset mid-dump:** assert `reset` asynchronously after the 2nd transfer.
  - Expect outputs at 0 immediately and no `done`.
  - A subsequent `start` with `waddr = 2`, unprimed, yields samples 0 and 1 only.

Source files
------------

// File: rtl/read_mem.sv
// Read-out engine for the circular capture buffer: snapshots the writer's
// pointer on start and streams every captured sample out oldest-first.
module read_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q,  base_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         idx_q,   idx_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        idx_d    = idx_q;
        o_data_d = o_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d = '0;
                    if (primed) begin
                        // Full buffer: the oldest sample sits at the write pointer.
                        base_d  = waddr;
                        count_d = FULL_COUNT;
                        state_d = S_FETCH;
                    end else begin
                        base_d  = '0;
                        count_d = {1'b0, waddr};
                        state_d = (waddr == '0) ? S_DONE : S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                o_data_d = rdata;
                state_d  = S_PRESENT;
            end
            S_PRESENT: begin
                if (o_ready) begin
                    idx_d   = idx_q + CW'(1);
                    state_d = (idx_q == count_q - CW'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together at the edge regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            o_data_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            o_data_q <= o_data_d;
        end
    end

    // Address wraps naturally in ADDR_WIDTH bits; stays put until idx advances.
    assign raddr   = base_q + idx_q[ADDR_WIDTH-1:0];
    assign o_data  = o_data_q;
    assign o_valid = (state_q == S_PRESENT);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_read_mem.sv
// Bench for read_mem: synchronous-read buffer model, randomized dumps and
// handshake, checked against the chronological-order address list.
module tb_read_mem;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       primed = 1'b0;
    logic       o_ready = 1'b0;
    logic [3:0] waddr = '0;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic [7:0] o_data;
    logic       o_valid, busy, done;

    logic [7:0] mem [16];

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] obs_addr[$];
    logic [7:0] obs_data[$];
    logic [3:0] exp_addr[$];
    int done_cnt, done_cyc, last_xfer, first_valid, held_cnt;
    bit timeout, retract, unstable, busy_after;

    read_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .waddr  (waddr),
        .primed (primed),
        .raddr  (raddr),
        .rdata  (rdata),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(1, 255));
    endtask

    // Reference: chronological order of the circular buffer.
    function automatic void expect_dump(bit pr, logic [3:0] wa);
        int n;
        int b;
        exp_addr.delete();
        n = pr ? 16 : int'(wa);
        b = pr ? int'(wa) : 0;
        for (int i = 0; i < n; i++) exp_addr.push_back(4'((b + i) % 16));
    endfunction

    // Drives one dump from IDLE and records what the DUT streamed out.
    task automatic run_dump(input bit pr, input logic [3:0] wa, input int ready_pct,
                            input int hold_first, input bit restart);
        int cyc;
        bit pending;
        logic [3:0] pa;
        logic [7:0] pd;
        obs_addr.delete();
        obs_data.delete();
        done_cnt = 0; done_cyc = -1; last_xfer = -1; first_valid = -1; held_cnt = 0;
        timeout = 0; retract = 0; unstable = 0; busy_after = 0;
        pending = 0; pa = '0; pd = '0; cyc = 0;
        primed = pr; waddr = wa; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        forever begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && busy !== 1'b0) busy_after = 1;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
            if (cyc >= 400) begin timeout = 1; break; end
            if (o_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (pending && o_valid !== 1'b1) retract = 1;
            if (pending && o_valid === 1'b1 && (o_data !== pd || raddr !== pa)) unstable = 1;
            if (restart && cyc == 4) begin
                start = 1'b1; primed = ~pr; waddr = wa + 4'd7;
            end else start = 1'b0;
            if (o_valid === 1'b1 && held_cnt < hold_first) begin
                o_ready = 1'b0; held_cnt++;
            end else o_ready = (int'($urandom_range(0, 99)) < ready_pct);
            if (o_valid === 1'b1 && o_ready) begin
                obs_addr.push_back(raddr);
                obs_data.push_back(o_data);
                last_xfer = cyc;
                pending = 0;
            end else begin
                pending = (o_valid === 1'b1);
                pa = raddr; pd = o_data;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; o_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        vectors++;
        if ({raddr, o_data, o_valid, busy, done} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: got raddr=%0d o_data=%0d valid=%b busy=%b done=%b, required all 0",
                     raddr, o_data, o_valid, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got valid=%b busy=%b done=%b, required 000", o_valid, busy, done);
        end
    endtask

    task automatic test_unprimed();
        fill_mem();
        expect_dump(1'b0, 4'd5);
        run_dump(1'b0, 4'd5, 100, 0, 1'b0);
        vectors++;
        if (obs_addr.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL unprimed_count: got %0d samples, required %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== mem[exp_addr[i]]) begin
                miscompares++;
                $display("FAIL unprimed_sample%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], mem[exp_addr[i]]);
            end
        end
        vectors++;
        if (first_valid != 2 || done_cyc != 15 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL unprimed_timing: got first_valid=%0d done_cyc=%0d dones=%0d, required 2 15 1",
                     first_valid, done_cyc, done_cnt);
        end
        vectors++;
        if ({timeout, retract, unstable, busy_after} !== 4'b0) begin
            miscompares++;
            $display("FAIL unprimed_protocol: got timeout/retract/unstable/busy_after=%b, required 0000",
                     {timeout, retract, unstable, busy_after});
        end
    endtask

    task automatic test_primed_wrap();
        fill_mem();
        expect_dump(1'b1, 4'd3);
        run_dump(1'b1, 4'd3, 100, 0, 1'b0);
        vectors++;
        if (obs_addr.size() != 16) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d samples, required 16", obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== mem[exp_addr[i]]) begin
                miscompares++;
                $display("FAIL wrap_sample%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], mem[exp_addr[i]]);
            end
        end
        vectors++;
        if (done_cyc != 48 || done_cnt != 1 || {timeout, retract, unstable, busy_after} !== 4'b0) begin
            miscompares++;
            $display("FAIL wrap_done: got done_cyc=%0d dones=%0d flags=%b, required 48 1 0000",
                     done_cyc, done_cnt, {timeout, retract, unstable, busy_after});
        end
    endtask

    task automatic test_empty();
        run_dump(1'b0, 4'd0, 100, 0, 1'b0);
        vectors++;
        if (obs_addr.size() != 0 || first_valid != -1) begin
            miscompares++;
            $display("FAIL empty_valid: got %0d samples first_valid=%0d, required none",
                     obs_addr.size(), first_valid);
        end
        vectors++;
        if (done_cyc != 0 || done_cnt != 1 || busy_after || timeout) begin
            miscompares++;
            $display("FAIL empty_done: got done_cyc=%0d dones=%0d busy_after=%b timeout=%b, required 0 1 0 0",
                     done_cyc, done_cnt, busy_after, timeout);
        end
    endtask

    task automatic test_backpressure();
        fill_mem();
        expect_dump(1'b0, 4'd6);
        run_dump(1'b0, 4'd6, 100, 5, 1'b0);
        vectors++;
        if (held_cnt != 5 || retract || unstable) begin
            miscompares++;
            $display("FAIL bp_hold: got held=%0d retract=%b unstable=%b, required 5 0 0",
                     held_cnt, retract, unstable);
        end
        vectors++;
        if (obs_addr.size() != exp_addr.size() || done_cyc != 23 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL bp_count: got %0d samples done_cyc=%0d dones=%0d, required %0d 23 1",
                     obs_addr.size(), done_cyc, done_cnt, exp_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== mem[exp_addr[i]]) begin
                miscompares++;
                $display("FAIL bp_sample%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], mem[exp_addr[i]]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        fill_mem();
        expect_dump(1'b0, 4'd5);
        run_dump(1'b0, 4'd5, 100, 0, 1'b1);
        vectors++;
        if (obs_addr.size() != exp_addr.size() || done_cnt != 1 || busy_after) begin
            miscompares++;
            $display("FAIL busy_start: got %0d samples dones=%0d busy_after=%b, required %0d 1 0",
                     obs_addr.size(), done_cnt, busy_after, exp_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== mem[exp_addr[i]]) begin
                miscompares++;
                $display("FAIL busy_sample%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], mem[exp_addr[i]]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int n;
        int cyc;
        bit saw_done;
        fill_mem();
        n = 0; saw_done = 0;
        primed = 1'b1; waddr = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; o_ready = 1'b1;
        for (cyc = 0; cyc < 100 && n < 2; cyc++) begin
            if (done === 1'b1) saw_done = 1;
            if (o_valid === 1'b1) n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL rst_pre: got %0d transfers before reset, required 2", n);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({raddr, o_data, o_valid, busy, done} !== 15'd0) begin
            miscompares++;
            $display("FAIL rst_async: got raddr=%0d o_data=%0h valid=%b busy=%b done=%b, required all 0",
                     raddr, o_data, o_valid, busy, done);
        end
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
        end
        reset = 1'b0; o_ready = 1'b0;
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) saw_done = 1;
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL rst_no_done: got done/busy after reset=1, required 0");
        end
        expect_dump(1'b0, 4'd2);
        run_dump(1'b0, 4'd2, 100, 0, 1'b0);
        vectors++;
        if (obs_addr.size() != 2 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL rst_fresh: got %0d samples dones=%0d, required 2 1", obs_addr.size(), done_cnt);
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== mem[exp_addr[i]]) begin
                miscompares++;
                $display("FAIL rst_sample%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], mem[exp_addr[i]]);
            end
        end
    endtask

    task automatic test_random();
        bit pr;
        logic [3:0] wa;
        for (int t = 0; t < 10; t++) begin
            fill_mem();
            pr = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            expect_dump(pr, wa);
            run_dump(pr, wa, int'($urandom_range(30, 100)), 0, 1'b0);
            vectors++;
            if (obs_addr.size() != exp_addr.size() || done_cnt != 1 ||
                {timeout, retract, unstable, busy_after} !== 4'b0) begin
                miscompares++;
                $display("FAIL rand%0d_dump: got %0d samples dones=%0d flags=%b, required %0d 1 0000",
                         t, obs_addr.size(), done_cnt, {timeout, retract, unstable, busy_after},
                         exp_addr.size());
            end
            vectors++;
            if (done_cyc != (exp_addr.size() == 0 ? 0 : last_xfer + 1)) begin
                miscompares++;
                $display("FAIL rand%0d_done: got done_cyc=%0d, required %0d", t, done_cyc,
                         exp_addr.size() == 0 ? 0 : last_xfer + 1);
            end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                vectors++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== mem[exp_addr[i]]) begin
                    miscompares++;
                    $display("FAIL rand%0d_sample%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                             t, i, obs_addr[i], obs_data[i], exp_addr[i], mem[exp_addr[i]]);
                end
            end
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_unprimed();
        test_primed_wrap();
        test_empty();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
